// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: the ROB packet exchanged with dispatch and retire,
// plus default sizing. Partial squash is selected with the ROB_PARTIAL_SQUASH_EN macro.
package reorder_buffer_pkg;

   localparam int N_DEFAULT      = 3;
   localparam int ROB_SZ_DEFAULT = 32;
   localparam int PREG_W         = 6;
   localparam int AREG_W         = 5;

   typedef struct packed {
      logic [PREG_W-1:0] T_new;
      logic [PREG_W-1:0] T_old;
      logic [AREG_W-1:0] arch_reg;
      logic              has_dest;
      logic              is_store;
      logic              halt;
      logic              illegal;
      logic [31:0]       NPC;
   } ROB_PACKET;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer between dispatch and retire.
// Define ROB_PARTIAL_SQUASH_EN to truncate at the mispredicted branch; otherwise a mispredict flushes all entries.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_SZ = ROB_SZ_DEFAULT,
   parameter int N      = N_DEFAULT
) (
   input  logic                         clock,
   input  logic                         reset,
   input  ROB_PACKET [N-1:0]            rob_inputs,
   input  logic [$clog2(N+1)-1:0]       rob_inputs_valid,
   output logic [$clog2(N+1)-1:0]       rob_spots,
   output logic [$clog2(ROB_SZ)-1:0]    rob_tail,
   output ROB_PACKET [N-1:0]            rob_outputs,
   output logic [$clog2(N+1)-1:0]       rob_outputs_valid,
   input  logic [$clog2(N+1)-1:0]       num_retiring,
   input  logic                         mispredict,
   input  logic [$clog2(ROB_SZ)-1:0]    mispredict_rob_idx
);

   localparam int IDX_W = $clog2(ROB_SZ);
   localparam int CNT_W = $clog2(ROB_SZ + 1);
   localparam int SC_W  = $clog2(N + 1);

   ROB_PACKET        entries_q [ROB_SZ];
   ROB_PACKET        entries_d [ROB_SZ];
   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] free_slots;
   logic [CNT_W-1:0] kept;

   // Outputs depend on registered state only, so retire never feeds dispatch combinationally.
   assign free_slots        = CNT_W'(ROB_SZ) - count_q;
   assign rob_spots         = (free_slots > CNT_W'(N)) ? SC_W'(N) : SC_W'(free_slots);
   assign rob_outputs_valid = (count_q > CNT_W'(N)) ? SC_W'(N) : SC_W'(count_q);
   assign rob_tail          = tail_q;

   // kept spans 1..ROB_SZ, so a full ROB with idx+1 == head keeps every entry.
   assign kept = CNT_W'(IDX_W'(mispredict_rob_idx - head_q)) + CNT_W'(1);

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_out
         assign rob_outputs[gi] = (SC_W'(gi) < rob_outputs_valid)
                                  ? entries_q[head_q + IDX_W'(gi)] : '0;
      end
   endgenerate

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q + IDX_W'(num_retiring);
      tail_d    = tail_q + IDX_W'(rob_inputs_valid);
      count_d   = count_q + CNT_W'(rob_inputs_valid) - CNT_W'(num_retiring);
      if (mispredict) begin
`ifdef ROB_PARTIAL_SQUASH_EN
         tail_d  = mispredict_rob_idx + IDX_W'(1);
         count_d = kept - CNT_W'(num_retiring);
`else
         tail_d  = head_d;
         count_d = '0;
`endif
      end else begin
         for (int i = 0; i < N; i++) begin
            if (i < int'(rob_inputs_valid)) begin
               entries_d[tail_q + IDX_W'(i)] = rob_inputs[i];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry payloads carry no reset; occupancy alone decides what is live.
   always_ff @(posedge clock) begin
      entries_q <= entries_d;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (rob_inputs_valid <= rob_spots);
         assert (num_retiring <= rob_outputs_valid);
`ifdef ROB_PARTIAL_SQUASH_EN
         if (mispredict) begin
            assert (CNT_W'(IDX_W'(mispredict_rob_idx - head_q)) < count_q);
            assert (CNT_W'(num_retiring) <= kept);
         end
`endif
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scoreboard bench for reorder_buffer with N=3, ROB_SZ=8; follows ROB_PARTIAL_SQUASH_EN if defined.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   localparam int N  = 3;
   localparam int SZ = 8;

   logic             clock = 1'b0;
   logic             reset;
   ROB_PACKET [N-1:0] rob_inputs;
   logic [1:0]       rob_inputs_valid;
   logic [1:0]       rob_spots;
   logic [2:0]       rob_tail;
   ROB_PACKET [N-1:0] rob_outputs;
   logic [1:0]       rob_outputs_valid;
   logic [1:0]       num_retiring;
   logic             mispredict;
   logic [2:0]       mispredict_rob_idx;

   int errors = 0;
   int checks = 0;
   int seq    = 0;
   int head_m = 0;
   int tail_m = 0;
   ROB_PACKET sb[$];

   always #5 clock = ~clock;

   reorder_buffer #(.ROB_SZ(SZ), .N(N)) dut (
      .clock(clock), .reset(reset),
      .rob_inputs(rob_inputs), .rob_inputs_valid(rob_inputs_valid),
      .rob_spots(rob_spots), .rob_tail(rob_tail),
      .rob_outputs(rob_outputs), .rob_outputs_valid(rob_outputs_valid),
      .num_retiring(num_retiring), .mispredict(mispredict),
      .mispredict_rob_idx(mispredict_rob_idx)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ROB_PACKET new_pkt();
      ROB_PACKET p;
      seq++;
      p.T_new    = 6'(seq);
      p.T_old    = 6'($urandom);
      p.arch_reg = 5'($urandom);
      p.has_dest = 1'($urandom);
      p.is_store = 1'($urandom);
      p.halt     = 1'b0;
      p.illegal  = 1'b0;
      p.NPC      = 32'h1000 + 32'(seq * 4);
      return p;
   endfunction

   function automatic int min3(int v);
      return (v > N) ? N : v;
   endfunction

   task automatic check_state(input string tag);
      int sz = sb.size();
      chk({tag, ".spots"}, 64'(rob_spots), 64'(min3(SZ - sz)));
      chk({tag, ".valid"}, 64'(rob_outputs_valid), 64'(min3(sz)));
      chk({tag, ".tail"}, 64'(rob_tail), 64'(tail_m));
      for (int i = 0; i < min3(sz); i++)
         chk($sformatf("%s.out%0d", tag, i), 64'(rob_outputs[i]), 64'(sb[i]));
   endtask

   // One cycle: drive, compare retiring lanes, clock, update the model, compare state.
   task automatic step(input string tag, input int nin, input int nret,
                       input bit mp, input int idx);
      ROB_PACKET pk [N];
      for (int i = 0; i < N; i++) begin
         pk[i] = (i < nin) ? new_pkt() : '0;
         rob_inputs[i] = pk[i];
      end
      rob_inputs_valid   = 2'(nin);
      num_retiring       = 2'(nret);
      mispredict         = mp;
      mispredict_rob_idx = 3'(idx);
      for (int i = 0; i < nret; i++)
         chk($sformatf("%s.ret%0d", tag, i), 64'(rob_outputs[i]), 64'(sb[i]));
      @(posedge clock);
      if (mp) begin
`ifdef ROB_PARTIAL_SQUASH_EN
         int kept = ((idx - head_m) & (SZ - 1)) + 1;
         while (sb.size() > kept) void'(sb.pop_back());
         for (int i = 0; i < nret; i++) void'(sb.pop_front());
         head_m = (head_m + nret) & (SZ - 1);
         tail_m = (idx + 1) & (SZ - 1);
`else
         sb.delete();
         head_m = (head_m + nret) & (SZ - 1);
         tail_m = head_m;
`endif
      end else begin
         for (int i = 0; i < nin; i++) sb.push_back(pk[i]);
         for (int i = 0; i < nret; i++) void'(sb.pop_front());
         head_m = (head_m + nret) & (SZ - 1);
         tail_m = (tail_m + nin) & (SZ - 1);
      end
      #1;
      rob_inputs_valid = '0;
      num_retiring     = '0;
      mispredict       = 1'b0;
      $display("step %-8s in=%0d ret=%0d mp=%0d idx=%0d -> head=%0d tail=%0d count=%0d",
               tag, nin, nret, mp, idx, head_m, tail_m, sb.size());
      check_state(tag);
   endtask

   initial begin
      ROB_PACKET first;
      ROB_PACKET entry3;
      reset              = 1'b1;
      rob_inputs         = '0;
      rob_inputs_valid   = '0;
      num_retiring       = '0;
      mispredict         = 1'b0;
      mispredict_rob_idx = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      $display("step reset -> head=0 tail=0 count=0");
      chk("reset.spots", 64'(rob_spots), 64'd3);
      chk("reset.valid", 64'(rob_outputs_valid), 64'd0);
      chk("reset.tail", 64'(rob_tail), 64'd0);
      chk("reset.outs", 64'(rob_outputs[0]) | 64'(rob_outputs[1]) | 64'(rob_outputs[2]), 64'd0);

      // Fill to full
      step("fill1", 3, 0, 0, 0);
      first = sb[0];
      step("fill2", 3, 0, 0, 0);
      step("fill3", 2, 0, 0, 0);
      chk("full.spots", 64'(rob_spots), 64'd0);
      chk("full.out0", 64'(rob_outputs[0]), 64'(first));
      entry3 = sb[3];

      // Wrap
      step("ret3", 0, 3, 0, 0);
      chk("wrap.spots", 64'(rob_spots), 64'd3);
      step("wrapdisp", 3, 0, 0, 0);
      chk("wrap.tail", 64'(rob_tail), 64'd3);
      chk("wrap.out0", 64'(rob_outputs[0]), 64'(entry3));

      // Simultaneous dispatch and retire at count 4
      step("ret3b", 0, 3, 0, 0);
      step("ret1", 0, 1, 0, 0);
      step("simul", 2, 1, 0, 0);
      chk("simul.spots", 64'(rob_spots), 64'd3);
      chk("simul.tail", 64'(rob_tail), 64'd5);

      // Squash with head=2, count=6, idx 4, retire 1, dispatch 2
      step("ret2", 0, 2, 0, 0);
      step("disp3", 3, 0, 0, 0);
      step("squash", 2, 1, 1, 4);
`ifdef ROB_PARTIAL_SQUASH_EN
      chk("squash.tail", 64'(rob_tail), 64'd5);
      chk("squash.valid", 64'(rob_outputs_valid), 64'd2);
`else
      chk("flush.tail", 64'(rob_tail), 64'd3);
      chk("flush.valid", 64'(rob_outputs_valid), 64'd0);
      chk("flush.spots", 64'(rob_spots), 64'd3);
`endif

      // Refill to full, then mispredict on the youngest-before-head branch (keeps all)
      step("refill1", 3, 0, 0, 0);
      step("refill2", 3, 0, 0, 0);
      if (sb.size() < SZ) step("refill3", SZ - sb.size(), 0, 0, 0);
      chk("refull.spots", 64'(rob_spots), 64'd0);
      step("mpfull", 0, 0, 1, (head_m + SZ - 1) & (SZ - 1));

      // Drain
      for (int k = 0; k < 4 && sb.size() > 0; k++)
         step("drain", 0, min3(sb.size()), 0, 0);
      chk("empty.valid", 64'(rob_outputs_valid), 64'd0);
      chk("empty.spots", 64'(rob_spots), 64'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular in-order buffer between dispatch and retire. Accepts up to `N` ROB_PACKETs per cycle from dispatch and presents the oldest `N` entries to retire as `rob_outputs`/`rob_outputs_valid`. Frees head entries when retire returns `num_retiring`. On a branch mispredict it truncates or flushes younger entries.

## Interface
- `ROB_SZ`, default 32: number of entries; must be a power of two and at least `N`.
- `N`, default `` `N `` from sys_defs.svh: superscalar width.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `rob_inputs` input ROB_PACKET[N-1:0]: dispatching entries, lane 0 oldest.
- `rob_inputs_valid` input NUM_SCALAR_BITS: number of lanes dispatching; lanes below the count are valid.
- `rob_spots` output NUM_SCALAR_BITS: entries dispatch may send this cycle.
- `rob_tail` output ROB_IDX: index lane 0 of dispatch will occupy; used by dispatch for branch tagging.
- `rob_outputs` output ROB_PACKET[N-1:0]: entries head through head+N-1, modulo ROB_SZ.
- `rob_outputs_valid` output NUM_SCALAR_BITS: number of valid `rob_outputs` lanes.
- `num_retiring` input NUM_SCALAR_BITS: head entries retire frees this cycle.
- `mispredict` input 1: branch mispredict resolved this cycle.
- `mispredict_rob_idx` input ROB_IDX: ROB index of the mispredicted branch.

## Operation
- State:
  - `entries[ROB_SZ]`.
  - `head` and `tail`: ROB_IDX, clog2(ROB_SZ) bits, wrap naturally.
  - `count`: clog2(ROB_SZ+1) bits.
- Combinational outputs, derived only from registered state:
  - `rob_spots = min(N, ROB_SZ - count)`. It does not credit same-cycle retires, so there is no combinational path from retire to dispatch.
  - `rob_outputs_valid = min(N, count)`.
  - `rob_outputs[i] = entries[head+i]`.
  - `rob_tail = tail`.
- Dispatch:
  - Lane i writes `entries[tail+i]` for i < `rob_inputs_valid`.
  - `tail += rob_inputs_valid`.
- Retire: `head += num_retiring`.
- Normal count update: `count_next = count + rob_inputs_valid - num_retiring`. Dispatch and retire in the same cycle are both applied.
- Mispredict takes priority over dispatch; dispatched lanes in that cycle are dropped.
  - `kept = ((mispredict_rob_idx - head) mod ROB_SZ) + 1`, range 1..ROB_SZ. This correctly handles a full ROB where idx+1 == head.
  - `tail_next = mispredict_rob_idx + 1`.
  - `count_next = kept - num_retiring`. Retire in the same cycle is still honoured; the branch may itself retire.
- Full is `count == ROB_SZ`, empty is `count == 0`. `head == tail` alone is ambiguous and is never used.
- Reset mid-operation: all in-flight entries are discarded. Entry contents are don't-care after reset; only `count`, `head` and `tail` are cleared.
- Illegal input (simulation assertions only; RTL behaviour is undefined):
  - `rob_inputs_valid > rob_spots`.
  - `num_retiring > rob_outputs_valid`.
  - Mispredict index outside head..tail-1.
  - `num_retiring > kept`.

## Timing
- Reset values:
  - `head = tail = count = 0`.
  - `rob_spots = N`, `rob_outputs_valid = 0`, `rob_tail = 0`.
  - `rob_outputs` = all-zero packets.
- Dispatch-to-visible latency is 1 cycle: an entry written at edge k appears on `rob_outputs` after edge k.
- Retire frees space with 1 cycle latency: `rob_spots` rises the cycle after `num_retiring > 0`.
- Mispredict takes effect at the next edge: `rob_tail` and `rob_spots` reflect the truncation the following cycle.
- No multi-cycle handshakes; every input is a single-cycle qualifier.

## Configuration
- `ROB_PARTIAL_SQUASH_EN` defined: mispredict truncates to the branch as described in Operation; older entries survive.
- `ROB_PARTIAL_SQUASH_EN` undefined:
  - Mispredict flushes everything: `head_next = head + num_retiring`, `tail_next = head_next`, `count_next = 0`.
  - `mispredict_rob_idx` is ignored. The front end must restart from the branch target only after the flush.

## Structure
- sys_defs.svh holds:
  - `` `ROB_SZ ``, `ROB_IDX` (`logic [$clog2(`ROB_SZ)-1:0]`) and `` `NUM_SCALAR_BITS ``.
  - `ROB_PACKET` with fields T_new, T_old, arch_reg, has_dest, is_store, halt, illegal and NPC, shared with dispatch and retire.
- Single module; no sub-module is warranted. Pointer wrap uses native ROB_IDX overflow.

## Test plan
Parameters for all scenarios: N=3, ROB_SZ=8, partial squash enabled unless noted.
- Reset: assert reset for 2 cycles -> `rob_spots`=3, `rob_outputs_valid`=0, `rob_tail`=0.
- Fill: dispatch 3, 3, 2 on consecutive cycles with no retire -> `count`=8, `rob_spots`=0, `rob_outputs_valid`=3, `rob_outputs[0]` = first packet dispatched.
- Wrap: from full (head=0), retire 3 -> next cycle head=3, `rob_spots`=3; dispatch 3 -> tail=3, `count`=8, `rob_outputs[0]` = original entry 3.
- Simultaneous events: `count`=4, dispatch 2 and retire 1 in the same cycle -> `count`=5, `rob_spots`=3, `rob_tail` advanced by 2.
- Partial squash: head=2, `count`=6, mispredict idx 4, `num_retiring`=1, dispatch 2 -> head=3, tail=5, `count`=2, dispatched lanes dropped.
- Full flush (macro undefined): same stimulus as partial squash -> head=3, tail=3, `count`=0, `rob_outputs_valid`=0, `rob_spots`=3.
